// File: rtl/qoi_types.sv
// Shared types for the QOI stream encoder: pixel layout, chunk ops, tags and the index hash.
package qoi_types;

    // Member order puts r in bits [7:0] and a in [31:24], matching px_data.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef enum logic [2:0] {OP_RUN, OP_INDEX, OP_DIFF, OP_LUMA, OP_RGB, OP_RGBA} op_t;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CLASSIFY, S_EMIT, S_TAIL} state_t;

    localparam logic [7:0] TAG_INDEX = 8'h00;
    localparam logic [7:0] TAG_DIFF  = 8'h40;
    localparam logic [7:0] TAG_LUMA  = 8'h80;
    localparam logic [7:0] TAG_RUN   = 8'hC0;
    localparam logic [7:0] TAG_RGB   = 8'hFE;
    localparam logic [7:0] TAG_RGBA  = 8'hFF;

    // The 11-bit sum may wrap; only the low 6 bits matter, so wrapping is harmless.
    function automatic logic [5:0] qoi_hash(input pixel_t p);
        logic [10:0] s;
        s = p.r * 11'd3 + p.g * 11'd5 + p.b * 11'd7 + p.a * 11'd11;
        return s[5:0];
    endfunction

endpackage

// File: rtl/qoi_classify.sv
// Combinational chunk selection for one pixel against the previous pixel and its index slot.
module qoi_classify
    import qoi_types::*;
(
    input  pixel_t            px,
    input  pixel_t            prev,
    input  pixel_t            ent,
    output op_t               op,
    output logic [5:0]        hash,
    output logic signed [8:0] dr,
    output logic signed [8:0] dg,
    output logic signed [8:0] db,
    output logic signed [9:0] dr_dg,
    output logic signed [9:0] db_dg
);

    assign hash  = qoi_hash(px);
    assign dr    = $signed({1'b0, px.r}) - $signed({1'b0, prev.r});
    assign dg    = $signed({1'b0, px.g}) - $signed({1'b0, prev.g});
    assign db    = $signed({1'b0, px.b}) - $signed({1'b0, prev.b});
    assign dr_dg = $signed({dr[8], dr}) - $signed({dg[8], dg});
    assign db_dg = $signed({db[8], db}) - $signed({dg[8], dg});

    // DIFF/LUMA/RGB all carry no alpha, so they are only legal when alpha is unchanged.
    always_comb begin
        op = OP_RGBA;
        if (px == prev)
            op = OP_RUN;
        else if (ent == px)
            op = OP_INDEX;
        else if (px.a == prev.a) begin
            if (dr >= -9'sd2 && dr <= 9'sd1 && dg >= -9'sd2 && dg <= 9'sd1 &&
                db >= -9'sd2 && db <= 9'sd1)
                op = OP_DIFF;
            else if (dg >= -9'sd32 && dg <= 9'sd31 && dr_dg >= -10'sd8 && dr_dg <= 10'sd7 &&
                     db_dg >= -10'sd8 && db_dg <= 10'sd7)
                op = OP_LUMA;
            else
                op = OP_RGB;
        end
    end

endmodule

// File: rtl/qoi_enc_stream.sv
// Streaming QOI encoder: one pixel in, its chunk bytes out, then the optional end marker.
module qoi_enc_stream
    import qoi_types::*;
#(
    parameter int CHANNELS = 4,
    parameter int MAX_RUN  = 62,
    parameter bit EMIT_END = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [29:0] size,
    input  logic [31:0] px_data,
    input  logic        px_valid,
    output logic        px_ready,
    output logic [7:0]  byte_o,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done,
    output logic [29:0] px_count
);

    state_t            state, state_nxt;
    pixel_t            pix, prev, ent;
    logic [63:0][31:0] idx_tbl;
    logic [5:0]        run, run_inc, cls_run, hash;
    logic [29:0]       size_q;
    logic [7:0][7:0]   obuf, cls_buf;
    logic [4:0][7:0]   ch;
    logic [2:0]        bcnt, len, cls_len, ch_len;
    logic [7:0]        run_byte;
    logic              last_q, last_px;
    op_t               op;
    logic signed [8:0] dr, dg, db, dr_b, dg_b, db_b, dgl;
    logic signed [9:0] dr_dg, db_dg, drg, dbg;

    assign ent = idx_tbl[hash];

    qoi_classify u_cls (
        .px    (pix),
        .prev  (prev),
        .ent   (ent),
        .op    (op),
        .hash  (hash),
        .dr    (dr),
        .dg    (dg),
        .db    (db),
        .dr_dg (dr_dg),
        .db_dg (db_dg)
    );

    assign dr_b = dr + 9'sd2;
    assign dg_b = dg + 9'sd2;
    assign db_b = db + 9'sd2;
    assign dgl  = dg + 9'sd32;
    assign drg  = dr_dg + 10'sd8;
    assign dbg  = db_dg + 10'sd8;

    always_comb begin
        ch     = '0;
        ch_len = 3'd0;
        case (op)
            OP_INDEX: begin ch[0] = TAG_INDEX | {2'b00, hash}; ch_len = 3'd1; end
            OP_DIFF:  begin ch[0] = TAG_DIFF | {2'b00, dr_b[1:0], dg_b[1:0], db_b[1:0]}; ch_len = 3'd1; end
            OP_LUMA:  begin
                ch[0] = TAG_LUMA | {2'b00, dgl[5:0]};
                ch[1] = {drg[3:0], dbg[3:0]};
                ch_len = 3'd2;
            end
            OP_RGB:   begin ch[0] = TAG_RGB; ch[1] = pix.r; ch[2] = pix.g; ch[3] = pix.b; ch_len = 3'd4; end
            OP_RGBA:  begin
                ch[0] = TAG_RGBA; ch[1] = pix.r; ch[2] = pix.g; ch[3] = pix.b; ch[4] = pix.a;
                ch_len = 3'd5;
            end
            default:  ;
        endcase
    end

    // A pending run is flushed ahead of the chunk of the pixel that breaks it.
    always_comb begin
        run_inc  = run + 6'd1;
        run_byte = TAG_RUN | {2'b00, run - 6'd1};
        last_px  = (px_count == size_q);
        cls_buf  = '0;
        cls_len  = 3'd0;
        cls_run  = 6'd0;
        if (op == OP_RUN) begin
            if (run_inc == 6'(MAX_RUN) || last_px) begin
                cls_buf[0] = TAG_RUN | {2'b00, run_inc - 6'd1};
                cls_len    = 3'd1;
            end else
                cls_run = run_inc;
        end else if (run != 6'd0) begin
            cls_buf = {16'h0, ch, run_byte};
            cls_len = ch_len + 3'd1;
        end else begin
            cls_buf = {24'h0, ch};
            cls_len = ch_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = (size == 30'd0) ? S_TAIL : S_FETCH;
            S_FETCH:    if (px_valid) state_nxt = S_CLASSIFY;
            S_CLASSIFY: state_nxt = (cls_len != 3'd0) ? S_EMIT : (last_px ? S_TAIL : S_FETCH);
            S_EMIT:     if (byte_ready && bcnt == len - 3'd1) state_nxt = last_q ? S_TAIL : S_FETCH;
            S_TAIL:     if (!EMIT_END || (byte_ready && bcnt == 3'd7)) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        px_ready   = (state == S_FETCH);
        busy       = (state != S_IDLE);
        byte_valid = (state == S_EMIT) || (state == S_TAIL && EMIT_END);
        byte_o     = 8'h00;
        if (state == S_EMIT)
            byte_o = obuf[bcnt];
        else if (state == S_TAIL && EMIT_END)
            byte_o = {7'd0, bcnt == 3'd7};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix      <= '0;
            prev     <= '0;
            idx_tbl  <= '0;
            run      <= '0;
            size_q   <= '0;
            px_count <= '0;
            obuf     <= '0;
            len      <= '0;
            bcnt     <= '0;
            last_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    prev     <= 32'hFF00_0000;
                    idx_tbl  <= '0;
                    run      <= '0;
                    px_count <= '0;
                    size_q   <= size;
                    bcnt     <= '0;
                end
                S_FETCH: if (px_valid) begin
                    pix      <= (CHANNELS == 3) ? {8'hFF, px_data[23:0]} : px_data;
                    px_count <= px_count + 30'd1;
                end
                S_CLASSIFY: begin
                    obuf   <= cls_buf;
                    len    <= cls_len;
                    run    <= cls_run;
                    last_q <= last_px;
                    prev   <= pix;
                    bcnt   <= '0;
                    if (op != OP_RUN && op != OP_INDEX) idx_tbl[hash] <= pix;
                end
                S_EMIT, S_TAIL: if (byte_valid && byte_ready)
                    bcnt <= (state_nxt != state) ? 3'd0 : bcnt + 3'd1;
                default: ;
            endcase
            done <= (state == S_TAIL) && (state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_qoi_enc_stream.sv
// Directed bench: RGBA and RGB encoder instances driven with hand-computed QOI byte streams.
module tb_qoi_enc_stream;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start4 = 1'b0, start3 = 1'b0, px_valid = 1'b0, byte_ready = 1'b0, sel3 = 1'b0;
    logic [29:0] size = '0;
    logic [31:0] px_data = '0;
    logic        r4, r3, bv4, bv3, bz4, bz3, d4, d3;
    logic [7:0]  b4, b3;
    logic [29:0] c4, c3;
    logic        o_px_ready, o_byte_valid, o_busy, o_done;
    logic [7:0]  o_byte_o;
    logic [29:0] o_px_count;
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] px_q[$];
    logic [7:0]  exp_q[$], got_q[$];

    always #5 clk = ~clk;

    qoi_enc_stream #(.CHANNELS(4), .MAX_RUN(62), .EMIT_END(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .size(size), .px_data(px_data),
        .px_valid(px_valid), .px_ready(r4), .byte_o(b4), .byte_valid(bv4),
        .byte_ready(byte_ready), .busy(bz4), .done(d4), .px_count(c4));

    qoi_enc_stream #(.CHANNELS(3), .MAX_RUN(62), .EMIT_END(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .size(size), .px_data(px_data),
        .px_valid(px_valid), .px_ready(r3), .byte_o(b3), .byte_valid(bv3),
        .byte_ready(byte_ready), .busy(bz3), .done(d3), .px_count(c3));

    assign o_px_ready   = sel3 ? r3  : r4;
    assign o_byte_valid = sel3 ? bv3 : bv4;
    assign o_byte_o     = sel3 ? b3  : b4;
    assign o_busy       = sel3 ? bz3 : bz4;
    assign o_done       = sel3 ? d3  : d4;
    assign o_px_count   = sel3 ? c3  : c4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] pxw(input int r, input int g, input int b, input int a);
        return {a[7:0], b[7:0], g[7:0], r[7:0]};
    endfunction

    task automatic exp_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic exp_end();
        exp_bytes(64'h0000_0000_0000_0001, 8);
    endtask

    task automatic encode(input string tag, input int n, input bit use3, input bit stall,
                          input bit restart);
        int pi, cyc, scnt;
        logic [7:0] held;
        bit got_done;
        got_q.delete();
        pi = 0; cyc = 0; scnt = 0; got_done = 0; held = '0;
        @(negedge clk);
        sel3 = use3; size = n[29:0];
        if (use3) start3 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; start4 = 1'b0;
        chk({tag, " busy"}, o_busy, 1);
        while (!got_done && cyc < 3000) begin
            px_valid = (pi < n);
            px_data  = (pi < n) ? px_q[pi] : 32'h0;
            if (stall && o_byte_valid && scnt < 5) begin
                if (scnt == 0) held = o_byte_o;
                else chk({tag, " stall hold"}, o_byte_o, held);
                scnt++;
                byte_ready = 1'b0;
            end else
                byte_ready = 1'b1;
            if (restart && cyc == 3) begin start4 = 1'b1; size = '0; end
            else start4 = 1'b0;
            #1;
            if (px_valid && o_px_ready) pi++;
            if (o_byte_valid && byte_ready) begin got_q.push_back(o_byte_o); scnt = 0; end
            @(negedge clk);
            cyc++;
            if (o_done) got_done = 1;
        end
        px_valid = 1'b0; byte_ready = 1'b0; start4 = 1'b0;
        chk({tag, " done"}, got_done, 1);
        chk({tag, " byte count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        chk({tag, " px_count"}, o_px_count, n);
        chk({tag, " idle"}, o_busy, 0);
        @(negedge clk);
        chk({tag, " done pulse"}, o_done, 0);
        px_q.delete(); exp_q.delete();
    endtask

    initial begin
        #12;
        chk("rst px_ready", o_px_ready, 0);
        chk("rst byte_valid", o_byte_valid, 0);
        chk("rst busy", o_busy, 0);
        chk("rst done", o_done, 0);
        chk("rst px_count", o_px_count, 0);
        chk("rst byte_o", o_byte_o, 0);
        chk("rst busy3", bz3, 0);
        @(negedge clk); rst_n = 1'b1;

        px_q.push_back(pxw(0, 0, 0, 255));
        exp_bytes(64'hC0, 1); exp_end();
        encode("single run", 1, 0, 0, 0);

        px_q.push_back(pxw(10, 20, 30, 255));
        px_q.push_back(pxw(11, 21, 29, 255));
        px_q.push_back(pxw(10, 20, 30, 255));
        exp_bytes(64'hFE0A_141E_7D09, 6); exp_end();
        encode("rgb diff index", 3, 0, 0, 1);

        for (int i = 0; i < 64; i++) px_q.push_back(pxw(0, 0, 0, 255));
        exp_bytes(64'hFDC1, 2); exp_end();
        encode("run split", 64, 0, 0, 0);

        px_q.push_back(pxw(1, 2, 3, 4));
        exp_bytes(64'hFF01_0203_04, 5); exp_end();
        encode("rgba stall", 1, 0, 1, 0);

        px_q.push_back(pxw(1, 2, 3, 8'h10));
        exp_bytes(64'hA279, 2); exp_end();
        encode("rgb3 luma", 1, 1, 0, 0);

        exp_end();
        encode("empty", 0, 0, 0, 0);

        px_q.push_back(pxw(0, 0, 0, 255));
        px_q.push_back(pxw(0, 0, 0, 255));
        px_q.push_back(pxw(5, 7, 9, 255));
        px_q.push_back(pxw(0, 0, 0, 255));
        exp_bytes(64'hC1A7_6A99_A6, 5); exp_end();
        encode("flush luma", 4, 0, 0, 0);

        px_q.push_back(pxw(0, 0, 0, 255));
        px_q.push_back(pxw(9, 9, 9, 8'h80));
        px_q.push_back(pxw(9, 9, 9, 8'h80));
        exp_bytes(64'hC0FF_0909_0980_C0, 7); exp_end();
        encode("flush rgba", 3, 0, 0, 0);

        // Abandon an image while its first chunk is being emitted.
        @(negedge clk);
        sel3 = 1'b0; size = 30'd3; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; px_valid = 1'b1; px_data = pxw(10, 20, 30, 255); byte_ready = 1'b0;
        for (int i = 0; i < 20 && !o_byte_valid; i++) @(negedge clk);
        chk("abort emitting", o_byte_valid, 1);
        px_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort byte_valid", o_byte_valid, 0);
        chk("abort busy", o_busy, 0);
        chk("abort px_count", o_px_count, 0);
        chk("abort byte_o", o_byte_o, 0);
        @(negedge clk); rst_n = 1'b1;

        px_q.push_back(pxw(10, 20, 30, 255));
        px_q.push_back(pxw(11, 21, 29, 255));
        px_q.push_back(pxw(10, 20, 30, 255));
        exp_bytes(64'hFE0A_141E_7D09, 6); exp_end();
        encode("after abort", 3, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
